// File: rtl/tt_um_piso_serializer_if.sv
// Pin bundle for the PISO serializer: clock enable, parallel byte, control byte and outputs.
interface tt_um_piso_serializer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // The driver of the pins (testbench or pad ring).
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // The serializer itself.
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_piso_serializer.sv
// 8-bit parallel-in serial-out serializer.
// The first bit leaves on the same edge that samples start. The shift register rotates,
// so after 8 bits it holds the captured byte again and loop mode can repeat it without a gap.
module tt_um_piso_serializer (
  input  logic                            clk,
  input  logic                            rst_n,
  tt_um_piso_serializer_if.slave          tt_io
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        lsb_q, lsb_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        sdata_q, sdata_d;
  logic        svalid_q, svalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic start_in;
  logic lsb_in;
  logic loop_in;

  assign start_in = tt_io.uio_in[0];
  assign lsb_in   = tt_io.uio_in[1];
  assign loop_in  = tt_io.uio_in[2];

  // Next-state and next-output logic; everything holds while ena is low.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    lsb_d     = lsb_q;
    bit_idx_d = bit_idx_q;
    sdata_d   = sdata_q;
    svalid_d  = svalid_q;
    busy_d    = busy_q;
    done_d    = done_q;

    if (tt_io.ena) begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            state_d   = StShift;
            lsb_d     = lsb_in;
            // Emit the first bit now and store the byte already rotated by one position.
            if (lsb_in) begin
              sdata_d = tt_io.ui_in[0];
              shreg_d = {tt_io.ui_in[0], tt_io.ui_in[7:1]};
            end else begin
              sdata_d = tt_io.ui_in[7];
              shreg_d = {tt_io.ui_in[6:0], tt_io.ui_in[7]};
            end
            svalid_d  = 1'b1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            bit_idx_d = 3'd0;
          end
        end

        StShift: begin
          if ((bit_idx_q == 3'd7) && !loop_in) begin
            state_d   = StDone;
            sdata_d   = 1'b0;
            svalid_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            // bit_idx wraps 7 -> 0 naturally when looping.
            bit_idx_d = bit_idx_q + 3'd1;
            if (lsb_q) begin
              sdata_d = shreg_q[0];
              shreg_d = {shreg_q[0], shreg_q[7:1]};
            end else begin
              sdata_d = shreg_q[7];
              shreg_d = {shreg_q[6:0], shreg_q[7]};
            end
          end
        end

        StDone: begin
          state_d = StIdle;
          done_d  = 1'b0;
        end

        default: begin
          state_d   = StIdle;
          sdata_d   = 1'b0;
          svalid_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          bit_idx_d = 3'd0;
        end
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= 8'h00;
      lsb_q     <= 1'b0;
      bit_idx_q <= 3'd0;
      sdata_q   <= 1'b0;
      svalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      lsb_q     <= lsb_d;
      bit_idx_q <= bit_idx_d;
      sdata_q   <= sdata_d;
      svalid_q  <= svalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tt_io.uo_out  = {1'b0, bit_idx_q, done_q, busy_q, svalid_q, sdata_q};
  assign tt_io.uio_out = 8'h00;
  assign tt_io.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_piso_serializer.sv
// Directed testbench for tt_um_piso_serializer.
module tb_tt_um_piso_serializer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tt_um_piso_serializer_if bus ();

  tt_um_piso_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uo_out for a SHIFT cycle: svalid=1, busy=1, done=0.
  function automatic logic [7:0] shift_word(input int idx, input logic bit_v);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {1'b0, i3, 1'b0, 1'b1, 1'b1, bit_v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Sends one frame from IDLE; exp lists the transmitted bits first-bit-first from bit 7 down.
  task automatic run_frame(input logic [7:0] data, input logic lsb, input logic [7:0] exp,
                           input logic hold, input string name);
    bus.ui_in  = data;
    bus.uio_in = {5'b0, 1'b0, lsb, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!hold) bus.uio_in[0] = 1'b0;
      chk($sformatf("%s_bit%0d", name, i), bus.uo_out, shift_word(i, exp[7-i]));
    end
    tick();
    chk($sformatf("%s_done", name), bus.uo_out, 8'h08);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'hFF;
    bus.uio_in = 8'h00;
    #12;
    chk("reset_uo_out", bus.uo_out, 8'h00);
    chk("reset_uio_out", bus.uio_out, 8'h00);
    chk("reset_uio_oe", bus.uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", bus.uo_out, 8'h00);
  endtask

  task automatic test_msb_first();
    run_frame(8'b10110110, 1'b0, 8'b10110110, 1'b0, "msb");
    tick();
    chk("msb_idle", bus.uo_out, 8'h00);
  endtask

  task automatic test_lsb_first();
    run_frame(8'b10110110, 1'b1, 8'b01101101, 1'b0, "lsb");
    tick();
    chk("lsb_idle", bus.uo_out, 8'h00);
  endtask

  // Loop repeats 8'h01 MSB-first; lsb_first changes after capture must not matter.
  task automatic test_loop();
    logic b;
    bus.ui_in  = 8'h01;
    bus.uio_in = 8'b0000_0101;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.uio_in = 8'b0000_0110;
      b = (c == 8 || c == 16);
      chk($sformatf("loop_c%0d", c), bus.uo_out, shift_word((c - 1) % 8, b));
    end
    bus.uio_in = 8'b0000_0010;
    for (int c = 21; c <= 24; c++) begin
      tick();
      b = (c == 24);
      chk($sformatf("loop_end_c%0d", c), bus.uo_out, shift_word((c - 1) % 8, b));
    end
    tick();
    chk("loop_done", bus.uo_out, 8'h08);
    bus.uio_in = 8'h00;
    tick();
    chk("loop_idle", bus.uo_out, 8'h00);
  endtask

  // New data and a start pulse mid-frame must not disturb the frame in flight.
  task automatic test_ignore_start();
    logic [7:0] exp;
    exp        = 8'b10100101;
    bus.ui_in  = 8'hA5;
    bus.uio_in = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.uio_in = (i == 2) ? 8'h01 : 8'h00;
      if (i == 2) bus.ui_in = 8'hFF;
      chk($sformatf("ign_bit%0d", i), bus.uo_out, shift_word(i, exp[7-i]));
    end
    tick();
    chk("ign_done", bus.uo_out, 8'h08);
    tick();
    chk("ign_idle", bus.uo_out, 8'h00);
  endtask

  task automatic test_ena_freeze();
    logic [7:0] exp;
    exp        = 8'b10110110;
    bus.ui_in  = exp;
    bus.uio_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.uio_in = 8'h00;
      chk($sformatf("ena_bit%0d", i), bus.uo_out, shift_word(i, exp[7-i]));
    end
    bus.ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ena_hold%0d", k), bus.uo_out, shift_word(4, exp[3]));
    end
    bus.ena = 1'b1;
    for (int i = 5; i < 8; i++) begin
      tick();
      chk($sformatf("ena_bit%0d", i), bus.uo_out, shift_word(i, exp[7-i]));
    end
    tick();
    chk("ena_done", bus.uo_out, 8'h08);
    tick();
    chk("ena_idle", bus.uo_out, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    exp        = 8'b11001010;
    bus.ui_in  = exp;
    bus.uio_in = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.uio_in = 8'h00;
      chk($sformatf("rstm_bit%0d", i), bus.uo_out, shift_word(i, exp[7-i]));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_async", bus.uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstm_no_done", bus.uo_out, 8'h00);
    tick();
    chk("rstm_idle", bus.uo_out, 8'h00);
    run_frame(8'b00111001, 1'b0, 8'b00111001, 1'b0, "rstm_new");
    tick();
    chk("rstm_new_idle", bus.uo_out, 8'h00);
  endtask

  // Start held high: frame, one DONE, one IDLE, then the next frame.
  task automatic test_back_to_back();
    run_frame(8'hC3, 1'b0, 8'b11000011, 1'b1, "b2b_a");
    tick();
    chk("b2b_idle_gap", bus.uo_out, 8'h00);
    run_frame(8'hC3, 1'b0, 8'b11000011, 1'b1, "b2b_b");
    bus.uio_in = 8'h00;
    tick();
    chk("b2b_idle_end", bus.uo_out, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_loop();
    test_ignore_start();
    test_ena_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
